// File: rtl/alu_writeback_if.sv
// Request/write-back bundle between controller, register file and the ALU write-back stage.
interface alu_writeback_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [1:0]       wa;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] i;
  logic [1:0]       WA;
  logic             WE;
  logic             busy;
  logic             done;
  logic             cf;
  logic             zf;

  modport master (
    output start, op, wa, S, D,
    input  i, WA, WE, busy, done, cf, zf
  );

  modport slave (
    input  start, op, wa, S, D,
    output i, WA, WE, busy, done, cf, zf
  );
endinterface

// File: rtl/alu_writeback.sv
// Execute/write-back stage: single-cycle ALU ops plus shift-add multiply, one active-low write pulse per op.
// Latency: 2 cycles accept-to-WB-exit for ALU ops, 9 for MUL; start while busy is dropped, not queued.
module alu_writeback #(
  parameter int WIDTH    = 8,
  parameter int MUL_ITER = 8
) (
  input logic           clk,
  input logic           rst,
  alu_writeback_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int CW = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_ITER - 1);

  logic [1:0]         state;
  logic [2:0]         op_q;
  logic [1:0]         wa_q;
  logic [WIDTH-1:0]   s_q;
  logic [WIDTH-1:0]   d_q;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   i_q;
  logic [1:0]         wa_out;
  logic               we_q;
  logic               done_q;
  logic               busy_q;
  logic               cf_q;
  logic               zf_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   exec_r;
  logic               exec_c;
  logic [2*WIDTH-1:0] acc_nxt;

  assign sum     = {1'b0, s_q} + {1'b0, d_q};
  assign diff    = {1'b0, s_q} - {1'b0, d_q};
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    exec_r = '0;
    exec_c = 1'b0;
    case (op_q)
      OP_ADD: begin exec_r = sum[WIDTH-1:0];  exec_c = sum[WIDTH];  end
      OP_SUB: begin exec_r = diff[WIDTH-1:0]; exec_c = diff[WIDTH]; end
      OP_AND: exec_r = s_q & d_q;
      OP_OR:  exec_r = s_q | d_q;
      OP_NOT: exec_r = ~s_q;
      OP_SHL: begin exec_r = {s_q[WIDTH-2:0], 1'b0}; exec_c = s_q[WIDTH-1]; end
      OP_SHR: begin exec_r = {1'b0, s_q[WIDTH-1:1]}; exec_c = s_q[0];       end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      wa_q   <= '0;
      s_q    <= '0;
      d_q    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      i_q    <= '0;
      wa_out <= '0;
      we_q   <= 1'b1;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      cf_q   <= 1'b0;
      zf_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            s_q    <= bus.S;
            d_q    <= bus.D;
            op_q   <= bus.op;
            wa_q   <= bus.wa;
            mcand  <= {{WIDTH{1'b0}}, bus.S};
            mplier <= bus.D;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= (bus.op == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          i_q    <= exec_r;
          wa_out <= wa_q;
          cf_q   <= exec_c;
          zf_q   <= (exec_r == '0);
          we_q   <= 1'b0;
          done_q <= 1'b1;
          state  <= ST_WB;
        end
        ST_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Final step folds into the result load so WB starts MUL_ITER cycles after accept.
          if (cnt == CNT_LAST) begin
            i_q    <= acc_nxt[WIDTH-1:0];
            wa_out <= wa_q;
            cf_q   <= |acc_nxt[2*WIDTH-1:WIDTH];
            zf_q   <= (acc_nxt[WIDTH-1:0] == '0);
            we_q   <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_WB;
          end
        end
        ST_WB: begin
          we_q   <= 1'b1;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.i    = i_q;
  assign bus.WA   = wa_out;
  assign bus.WE   = we_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.cf   = cf_q;
  assign bus.zf   = zf_q;
endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: transaction-level reference model checked every cycle, plus directed literal cases.
module tb_alu_writeback;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  alu_writeback_if #(.WIDTH(8)) bus ();

  alu_writeback #(.WIDTH(8), .MUL_ITER(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the opcode table, in plain integer arithmetic.
  function automatic void ref_op(input logic [2:0] op, input logic [7:0] s, input logic [7:0] d,
                                 output logic [7:0] r, output logic c);
    int unsigned a, b, t;
    a = s;
    b = d;
    t = 0;
    c = 1'b0;
    case (op)
      3'd0: begin t = a + b; c = (t > 255); end
      3'd1: begin t = (a + 256 - b) % 256; c = (a < b); end
      3'd2: t = a & b;
      3'd3: t = a | b;
      3'd4: t = 255 - a;
      3'd5: begin t = (a * 2) % 256; c = (a >= 128); end
      3'd6: begin t = a / 2; c = (a % 2 == 1); end
      default: begin t = a * b; c = (t > 255); end
    endcase
    r = 8'(t % 256);
  endfunction

  // Model: an accepted op produces a WB cycle a fixed number of cycles later.
  int         cyc = 0;
  bit         mvalid = 0;
  bit         pend = 0;
  int         wb_k = 0;
  logic [7:0] p_r;
  logic       p_c;
  logic [1:0] p_wa;
  logic [7:0] m_i = 0;
  logic [1:0] m_wa = 0;
  logic       m_cf = 0, m_zf = 0, m_done = 0, m_busy = 0;

  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0;
    if (rst) begin
      mvalid = 1;
      pend = 0;
      m_i = 0; m_wa = 0; m_cf = 0; m_zf = 0;
    end else begin
      if (pend && cyc == wb_k) begin
        m_i = p_r; m_wa = p_wa; m_cf = p_c; m_zf = (p_r == 0);
        m_done = 1'b1;
      end
      if (pend && cyc == wb_k + 1) begin
        pend = 0;
      end else if (!pend && bus.start) begin
        ref_op(bus.op, bus.S, bus.D, p_r, p_c);
        p_wa = bus.wa;
        wb_k = cyc + ((bus.op == 3'd7) ? 8 : 1);
        pend = 1;
      end
    end
    m_busy = pend;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("WE",   32'(bus.WE),   32'(!m_done));
      chk("i",    32'(bus.i),    32'(m_i));
      chk("WA",   32'(bus.WA),   32'(m_wa));
      chk("cf",   32'(bus.cf),   32'(m_cf));
      chk("zf",   32'(bus.zf),   32'(m_zf));
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [7:0] s, input logic [7:0] d,
                        input logic [1:0] wa, input logic [7:0] ei, input logic ec,
                        input logic ez, input int lat);
    int n;
    bus.start = 1'b1; bus.op = op; bus.S = s; bus.D = d; bus.wa = wa;
    @(negedge clk);
    bus.start = 1'b0;
    bus.S = 8'($urandom);
    bus.D = 8'($urandom);
    n = 0;
    while (!bus.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("lat", 32'(n), 32'(lat));
    chk("lit_i",  32'(bus.i),  32'(ei));
    chk("lit_WA", 32'(bus.WA), 32'(wa));
    chk("lit_WE", 32'(bus.WE), 32'd0);
    chk("lit_cf", 32'(bus.cf), 32'(ec));
    chk("lit_zf", 32'(bus.zf), 32'(ez));
    @(negedge clk);
  endtask

  initial begin
    int dcnt;
    bus.start = 1'b1; bus.op = 3'd0; bus.wa = 2'd0; bus.S = 8'h55; bus.D = 8'h22;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_WE",   32'(bus.WE),   32'd1);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    run_op(3'b000, 8'hF0, 8'h20, 2'b01, 8'h10, 1'b1, 1'b0, 1);
    run_op(3'b001, 8'h35, 8'h35, 2'b10, 8'h00, 1'b0, 1'b1, 1);
    run_op(3'b001, 8'h01, 8'h02, 2'b00, 8'hFF, 1'b1, 1'b0, 1);
    run_op(3'b111, 8'h13, 8'h11, 2'b01, 8'h43, 1'b1, 1'b0, 8);
    run_op(3'b111, 8'h0F, 8'h03, 2'b10, 8'h2D, 1'b0, 1'b0, 8);
    run_op(3'b101, 8'h81, 8'h00, 2'b10, 8'h02, 1'b1, 1'b0, 1);
    run_op(3'b110, 8'h81, 8'h00, 2'b11, 8'h40, 1'b1, 1'b0, 1);

    // start held through a whole MUL including its WB cycle: exactly one write-back
    dcnt = 0;
    bus.start = 1'b1; bus.op = 3'b111; bus.S = 8'h07; bus.D = 8'h09; bus.wa = 2'b01;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    bus.start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("one_wb", 32'(dcnt), 32'd1);
    chk("mul_held_i", 32'(bus.i), 32'h3F);

    // abort a MUL on its fourth step
    bus.start = 1'b1; bus.op = 3'b111; bus.S = 8'hFF; bus.D = 8'hFF; bus.wa = 2'b10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_cf",   32'(bus.cf),   32'd0);
    chk("abort_i",    32'(bus.i),    32'd0);
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (!bus.WE) dcnt++;
    end
    chk("abort_nowrite", 32'(dcnt), 32'd0);

    // random traffic, occasional resets, operands scrambled every cycle
    for (int k = 0; k < 2000; k++) begin
      rst       = ($urandom_range(0, 149) == 0);
      bus.start = ($urandom_range(0, 2) != 0);
      bus.op    = 3'($urandom);
      bus.wa    = 2'($urandom);
      case ($urandom_range(0, 5))
        0: bus.S = 8'h00;
        1: bus.S = 8'hFF;
        default: bus.S = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: bus.D = 8'h00;
        1: bus.D = bus.S;
        default: bus.D = 8'($urandom);
      endcase
      @(negedge clk);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
